// File: rtl/seq_bin2bcd.sv
// rtl/seq_bin2bcd.sv - iterative signed/unsigned binary-to-BCD converter (double dabble)
module seq_bin2bcd #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                signed_mode,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic                neg,
    output logic [WIDTH-1:0]    abs_bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);

    // Scratch holds every decimal digit WIDTH bits can produce, so overflow is exact.
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
    localparam int SD         = (MIN_DIGITS > DIGITS) ? MIN_DIGITS : DIGITS;
    localparam int SW         = 4 * SD;
    localparam int CW         = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] bin_q;
    logic             sm_q;
    logic             neg_int;
    logic [WIDTH-1:0] mag_int;
    logic [WIDTH-1:0] mag_shift;
    logic [WIDTH-1:0] load_mag;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    scratch_adj;
    logic [CW-1:0]    cnt;
    logic             ovf_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Two's-complement negate wraps, so the most negative operand maps to 2^(WIDTH-1).
    assign load_mag = (sm_q & bin_q[WIDTH-1]) ? (~bin_q + WIDTH'(1)) : bin_q;

    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < SD; i++) begin
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + ((scratch[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    always_comb begin
        ovf_int = 1'b0;
        for (int i = DIGITS; i < SD; i++) begin
            ovf_int = ovf_int | (|scratch[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q     <= '0;
            sm_q      <= 1'b0;
            neg_int   <= 1'b0;
            mag_int   <= '0;
            mag_shift <= '0;
            scratch   <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            neg       <= 1'b0;
            abs_bin   <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin;
                        sm_q  <= signed_mode;
                    end
                end
                LOAD: begin
                    neg_int   <= sm_q & bin_q[WIDTH-1];
                    mag_int   <= load_mag;
                    mag_shift <= load_mag;
                    scratch   <= '0;
                    cnt       <= CW'(WIDTH);
                end
                SHIFT: begin
                    scratch   <= {scratch_adj[SW-2:0], mag_shift[WIDTH-1]};
                    mag_shift <= mag_shift << 1;
                    cnt       <= cnt - CW'(1);
                end
                FINISH: begin
                    neg      <= neg_int;
                    abs_bin  <= mag_int;
                    overflow <= ovf_int;
                    bcd      <= ovf_int ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb/tb_seq_bin2bcd.sv - bench for seq_bin2bcd at three parameter sets
module tb_seq_bin2bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [9:0]  bin10 = '0;
    logic [15:0] bin16 = '0;

    logic        busy0, done0, neg0, ovf0;
    logic [9:0]  abs0;
    logic [15:0] bcd0;
    logic        busy1, done1, neg1, ovf1;
    logic [9:0]  abs1;
    logic [11:0] bcd1;
    logic        busy2, done2, neg2, ovf2;
    logic [15:0] abs2;
    logic [19:0] bcd2;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] prev_bcd0 = '0;
    logic [63:0] prev_bcd2 = '0;

    always #5 clk = ~clk;

    seq_bin2bcd #(.WIDTH(10), .DIGITS(4)) u0 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .bin(bin10),
        .busy(busy0), .done(done0), .neg(neg0), .abs_bin(abs0), .bcd(bcd0), .overflow(ovf0));
    seq_bin2bcd #(.WIDTH(10), .DIGITS(3)) u1 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .bin(bin10),
        .busy(busy1), .done(done1), .neg(neg1), .abs_bin(abs1), .bcd(bcd1), .overflow(ovf1));
    seq_bin2bcd #(.WIDTH(16), .DIGITS(5)) u2 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .bin(bin16),
        .busy(busy2), .done(done2), .neg(neg2), .abs_bin(abs2), .bcd(bcd2), .overflow(ovf2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: magnitude by modular arithmetic, digits by repeated /10.
    function automatic void model(input logic [63:0] v, input int w, input int d, input bit sm,
                                  output logic n, output logic [63:0] mag,
                                  output logic [63:0] bcd, output logic ov);
        longint unsigned m;
        longint unsigned lim;
        m = v & ((64'd1 << w) - 64'd1);
        n = sm && v[w-1];
        if (n) m = (64'd1 << w) - m;
        mag = m;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        lim = lim - 1;
        ov = (m > lim);
        if (ov) m = lim;
        bcd = '0;
        for (int i = 0; i < d; i++) begin
            bcd = bcd | (64'(m % 10) << (4 * i));
            m = m / 10;
        end
    endfunction

    task automatic convert(input bit sm, input logic [9:0] b10, input logic [15:0] b16, input bit poke);
        logic n0, n1, n2, o0, o1, o2;
        logic [63:0] m0, m1, m2, c0, c1, c2;
        int t0, t1, t2, p0, p1, p2;
        model(64'(b10), 10, 4, sm, n0, m0, c0, o0);
        model(64'(b10), 10, 3, sm, n1, m1, c1, o1);
        model(64'(b16), 16, 5, sm, n2, m2, c2, o2);
        t0 = -1; t1 = -1; t2 = -1; p0 = 0; p1 = 0; p2 = 0;
        @(negedge clk);
        start = 1'b1; signed_mode = sm; bin10 = b10; bin16 = b16;
        @(posedge clk); #1;
        start = 1'b0; signed_mode = ~sm; bin10 = 10'($urandom); bin16 = 16'($urandom);
        chk("busy_rise", 64'(busy0), 64'd1);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (poke && cyc == 3) begin start = 1'b1; bin10 = ~b10; bin16 = ~b16; end
            if (poke && cyc == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done0) begin p0++; if (t0 < 0) t0 = cyc; end
            if (done1) begin p1++; if (t1 < 0) t1 = cyc; end
            if (done2) begin p2++; if (t2 < 0) t2 = cyc; end
            if (cyc == 5) begin
                chk("hold_bcd0", 64'(bcd0), prev_bcd0);
                chk("hold_bcd2", 64'(bcd2), prev_bcd2);
            end
        end
        chk("lat0", 64'(t0), 64'd12);
        chk("lat1", 64'(t1), 64'd12);
        chk("lat2", 64'(t2), 64'd18);
        chk("pulses", 64'(p0 + p1 + p2), 64'd3);
        chk("busy_idle", 64'({busy0, busy1, busy2}), 64'd0);
        chk("neg0", 64'(neg0), 64'(n0));
        chk("abs0", 64'(abs0), m0);
        chk("bcd0", 64'(bcd0), c0);
        chk("ovf0", 64'(ovf0), 64'(o0));
        chk("neg1", 64'(neg1), 64'(n1));
        chk("abs1", 64'(abs1), m1);
        chk("bcd1", 64'(bcd1), c1);
        chk("ovf1", 64'(ovf1), 64'(o1));
        chk("neg2", 64'(neg2), 64'(n2));
        chk("abs2", 64'(abs2), m2);
        chk("bcd2", 64'(bcd2), c2);
        chk("ovf2", 64'(ovf2), 64'(o2));
        prev_bcd0 = c0;
        prev_bcd2 = c2;
    endtask

    initial begin
        logic n, o;
        logic [63:0] m, c;
        int dn, t_a, t_b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'({busy0, done0, neg0, ovf0, busy2, done2}), 64'd0);
        chk("rst_bcd0", 64'(bcd0), 64'd0);
        chk("rst_abs0", 64'(abs0), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(1'b1, 10'd500, 16'h8000, 1'b0);
        for (int k = 0; k < 10; k++) convert(1'b1, 10'(500 - 63 * k), 16'($urandom), 1'b0);
        convert(1'b1, 10'h200, 16'h7fff, 1'b0);
        convert(1'b0, 10'h3ff, 16'hffff, 1'b0);
        convert(1'b0, 10'd0, 16'd0, 1'b0);
        convert(1'b0, 10'd999, 16'd9999, 1'b0);
        convert(1'b1, 10'h1ff, 16'h8001, 1'b1);
        convert(1'b0, 10'd1000, 16'd12345, 1'b1);

        // Abort a conversion mid-shift; no result and no done may appear.
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; bin10 = 10'd777; bin16 = 16'd4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_flags", 64'({busy0, done0, neg0, ovf0, busy1, busy2, done2}), 64'd0);
        chk("abort_bcd0", 64'(bcd0), 64'd0);
        chk("abort_abs0", 64'(abs0), 64'd0);
        chk("abort_bcd2", 64'(bcd2), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_bcd0 = '0;
        prev_bcd2 = '0;
        dn = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (done0 || done1 || done2) dn++;
        end
        chk("abort_nodone", 64'(dn), 64'd0);
        convert(1'b1, 10'h355, 16'h1234, 1'b0);

        // Start held high: the second conversion is accepted on the done edge.
        model(64'd321, 10, 4, 1'b0, n, m, c, o);
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; bin10 = 10'd321; bin16 = 16'd321;
        @(posedge clk); #1;
        dn = 0; t_a = -1; t_b = -1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk); #1;
            if (done0) begin
                dn++;
                if (t_a < 0) t_a = cyc; else t_b = cyc;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(dn), 64'd2);
        chk("b2b_first", 64'(t_a), 64'd12);
        chk("b2b_second", 64'(t_b), 64'd25);
        chk("b2b_bcd0", 64'(bcd0), c);
        repeat (25) @(posedge clk);
        prev_bcd0 = c;
        model(64'd321, 16, 5, 1'b0, n, m, c, o);
        prev_bcd2 = c;

        for (int r = 0; r < 20; r++) begin
            convert(1'($urandom), 10'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
